br_resolver: RTL

Execute-stage branch resolution unit. It is the consuming end of the fetch predictor's prediction stream and the producer of that predictor's br_sig/miss_pred training inputs. Fetch pushes each predicted branch/JAL into an in-order prediction queue. Execute presents the resolved outcome; the block pops the queue head, compares prediction against actual, and issues the training pulse, the PC redirect and the pipeline flush.

---
 rtl/br_resolver_if.sv | 52 +++++
 rtl/br_resolver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/br_resolver_if.sv
`default_nettype none
// ============================================================================
// Module      : br_resolver_if
// Description : Bundle of prediction-push, resolve, JALR and training/redirect
//               signals between fetch/execute and the branch resolver.
// Revision    : 1.0 - initial release
// ============================================================================
interface br_resolver_if;
    // Fetch-side prediction push
    logic        pred_valid_i;
    logic        pred_taken_i;
    logic [31:0] pred_pc_i;
    logic [31:0] pred_target_i;
    logic        pred_ready_o;

    // Execute-side resolution
    logic        res_valid_i;
    logic        res_taken_i;
    logic [31:0] res_pc_i;
    logic [31:0] res_target_i;
    logic        jalr_valid_i;
    logic [31:0] jalr_target_i;

    // Training, redirect and status
    logic        br_sig_o;
    logic        miss_pred_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic        err_o;
    logic [31:0] stat_branches_o;
    logic [31:0] stat_misses_o;

    // Pipeline side: drives pushes/resolves, consumes training and redirect
    modport master (
        output pred_valid_i, pred_taken_i, pred_pc_i, pred_target_i,
        output res_valid_i, res_taken_i, res_pc_i, res_target_i,
        output jalr_valid_i, jalr_target_i,
        input  pred_ready_o, br_sig_o, miss_pred_o, redirect_o, redirect_pc_o,
        input  flush_o, err_o, stat_branches_o, stat_misses_o
    );

    // Resolver side
    modport slave (
        input  pred_valid_i, pred_taken_i, pred_pc_i, pred_target_i,
        input  res_valid_i, res_taken_i, res_pc_i, res_target_i,
        input  jalr_valid_i, jalr_target_i,
        output pred_ready_o, br_sig_o, miss_pred_o, redirect_o, redirect_pc_o,
        output flush_o, err_o, stat_branches_o, stat_misses_o
    );
endinterface
`default_nettype wire

// File: rtl/br_resolver.sv
`default_nettype none
// ============================================================================
// Module      : br_resolver
// Description : Execute-stage branch resolution. Holds fetch predictions in an
//               in-order queue, compares the head against the resolved
//               outcome, emits predictor training, PC redirect and flush.
//               Optional macro BR_RESOLVER_STATS_EN enables the branch and
//               mispredict statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module br_resolver #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    br_resolver_if.slave  bus
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_ptr_w  = c_addr_w + 1;
    localparam int c_cnt_w  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Prediction queue storage (data only, validity is carried by the pointers)
    logic [31:0]          r_q_pc     [DEPTH];
    logic [31:0]          r_q_target [DEPTH];
    logic                 r_q_taken  [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_flush_cnt;

    // Registered outputs
    logic                 r_pred_ready;
    logic                 r_br_sig;
    logic                 r_miss_pred;
    logic                 r_redirect;
    logic [31:0]          r_redirect_pc;
    logic                 r_flush;
    logic                 r_err;

    // Combinational decode
    logic [c_ptr_w-1:0]   w_count;
    logic [c_ptr_w-1:0]   w_count_next;
    logic                 w_empty;
    logic                 w_idle;
    logic                 w_push;
    logic                 w_res;
    logic                 w_pop;
    logic                 w_jalr;
    logic [c_addr_w-1:0]  w_head_idx;
    logic [31:0]          w_head_pc;
    logic [31:0]          w_head_target;
    logic                 w_head_taken;
    logic                 w_mis;
    logic                 w_redirect;
    logic [31:0]          w_redirect_pc;
    logic                 w_err;

    assign w_count      = r_wr_ptr - r_rd_ptr;
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_idle       = (r_state == ST_IDLE);

    // pred_ready is already low while full or flushing, so it gates the push
    assign w_push       = bus.pred_valid_i && r_pred_ready;
    assign w_res        = w_idle && bus.res_valid_i;
    assign w_pop        = w_res && !w_empty;
    // A JALR colliding with a resolve is dropped; the resolve takes priority
    assign w_jalr       = w_idle && bus.jalr_valid_i && !bus.res_valid_i;

    assign w_head_idx    = r_rd_ptr[c_addr_w-1:0];
    assign w_head_pc     = r_q_pc[w_head_idx];
    assign w_head_target = r_q_target[w_head_idx];
    assign w_head_taken  = r_q_taken[w_head_idx];

    // Target only matters when the branch was actually taken
    assign w_mis = (w_head_taken != bus.res_taken_i) ||
                   (bus.res_taken_i && (w_head_target != bus.res_target_i));

    assign w_redirect    = (w_pop && w_mis) || w_jalr;
    assign w_redirect_pc = w_jalr           ? bus.jalr_target_i :
                           bus.res_taken_i  ? bus.res_target_i  :
                                              bus.res_pc_i + 32'd4;

    // Protocol errors: resolve with nothing queued, PC out of order, or a
    // JALR arriving in the same cycle as a resolve
    assign w_err = w_res && (w_empty || (w_head_pc != bus.res_pc_i) || bus.jalr_valid_i);

    assign w_count_next = w_count + c_ptr_w'(w_push) - c_ptr_w'(w_pop);

    // Queue data write; entries past the read pointer are never observed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr[c_addr_w-1:0]]     <= bus.pred_pc_i;
            r_q_target[r_wr_ptr[c_addr_w-1:0]] <= bus.pred_target_i;
            r_q_taken[r_wr_ptr[c_addr_w-1:0]]  <= bus.pred_taken_i;
        end
    end

    // Resolution FSM, queue pointers and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_flush_cnt   <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_pred_ready  <= 1'b1;
            r_br_sig      <= 1'b0;
            r_miss_pred   <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_flush       <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_br_sig    <= 1'b0;
            r_miss_pred <= 1'b0;
            r_redirect  <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_br_sig    <= w_pop;
                    r_miss_pred <= w_pop && w_mis;
                    r_err       <= w_err;
                    if (w_redirect) begin
                        // Everything still queued is wrong-path: drop it,
                        // including any push landing this cycle
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= w_redirect_pc;
                        r_state       <= ST_FLUSH;
                        r_flush_cnt   <= '0;
                        r_flush       <= 1'b1;
                        r_wr_ptr      <= '0;
                        r_rd_ptr      <= '0;
                        r_pred_ready  <= 1'b0;
                    end else begin
                        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_pred_ready <= (w_count_next != c_ptr_w'(DEPTH));
                    end
                end
                ST_FLUSH: begin
                    // All pipeline inputs are ignored while flushing
                    if (r_flush_cnt == c_cnt_w'(FLUSH_CYCLES - 1)) begin
                        r_state      <= ST_IDLE;
                        r_flush      <= 1'b0;
                        r_pred_ready <= 1'b1;
                    end else begin
                        r_flush_cnt  <= r_flush_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pred_ready_o  = r_pred_ready;
    assign bus.br_sig_o      = r_br_sig;
    assign bus.miss_pred_o   = r_miss_pred;
    assign bus.redirect_o    = r_redirect;
    assign bus.redirect_pc_o = r_redirect_pc;
    assign bus.flush_o       = r_flush;
    assign bus.err_o         = r_err;

`ifdef BR_RESOLVER_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_misses;

    // Count training strobes and the mispredicts among them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_branches <= '0;
            r_stat_misses   <= '0;
        end else if (r_br_sig) begin
            r_stat_branches <= r_stat_branches + 32'd1;
            if (r_miss_pred) r_stat_misses <= r_stat_misses + 32'd1;
        end
    end

    assign bus.stat_branches_o = r_stat_branches;
    assign bus.stat_misses_o   = r_stat_misses;
`else
    assign bus.stat_branches_o = '0;
    assign bus.stat_misses_o   = '0;
`endif

endmodule
`default_nettype wire
